// File: rtl/dff_bank_rr_writer_if.sv
// dff_bank_rr_writer_if: requester-side and register-side signals of the round-robin writer
interface dff_bank_rr_writer_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int SW = $clog2(NREQ);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic                  q_upd;
    logic [SW-1:0]         q_src;
    modport master (output req, lock, wdata, input gnt, q, q_valid, q_upd, q_src);
    modport slave  (input req, lock, wdata, output gnt, q, q_valid, q_upd, q_src);
endinterface

// File: rtl/dff_bank_rr_writer.sv
// dff_bank_rr_writer: round-robin owner arbitration and write sequencing for a shared register
module dff_bank_rr_writer #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input logic clk,
    input logic rst,
    dff_bank_rr_writer_if.slave bus
);
    localparam int SW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [SW:0] NR = (SW+1)'(NREQ);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state;
    logic [SW-1:0] last;
    logic [HW-1:0] hold_cnt;
    logic [SW-1:0] win;
    logic [SW:0]   idx;
    logic          any, wr, rel;

    // last always equals the owner while in OWN, so one scan serves both grant paths
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = {1'b0, last} + (SW+1)'(k);
            idx = idx >= NR ? idx - NR : idx;
            if (bus.req[idx[SW-1:0]]) win = idx[SW-1:0];
        end
    end

    assign any = |bus.req;
    assign wr  = state == OWN && bus.req[last];
    assign rel = state == OWN && (!bus.req[last] || !bus.lock[last] || hold_cnt == HMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus.gnt     <= '0;
            bus.q       <= '0;
            bus.q_valid <= 1'b0;
            bus.q_upd   <= 1'b0;
            bus.q_src   <= '0;
            last        <= SW'(NREQ - 1);
            hold_cnt    <= '0;
        end else begin
            bus.q_upd <= wr;
            if (wr) begin
                bus.q       <= bus.wdata[last*WIDTH +: WIDTH];
                bus.q_src   <= last;
                bus.q_valid <= 1'b1;
                hold_cnt    <= hold_cnt + 1'b1;
            end
            if ((state == IDLE || rel) && any) begin
                state    <= OWN;
                bus.gnt  <= NREQ'(1) << win;
                last     <= win;
                hold_cnt <= '0;
            end else if (rel) begin
                state   <= IDLE;
                bus.gnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dff_bank_rr_writer.sv
// tb_dff_bank_rr_writer: directed vectors with hand-computed expectations
module tb_dff_bank_rr_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    dff_bank_rr_writer_if #(.NREQ(4), .WIDTH(8)) bus ();

    dff_bank_rr_writer #(.NREQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [7:0] qv,
                           input logic u, input logic [1:0] s);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".q"}, 32'(bus.q), 32'(qv));
        chk({tag, ".q_upd"}, 32'(bus.q_upd), 32'(u));
        chk({tag, ".q_src"}, 32'(bus.q_src), 32'(s));
    endtask

    initial begin
        bus.req   = '0;
        bus.lock  = '0;
        bus.wdata = '0;
        tick();
        tick();
        chk_out("reset", 4'b0000, 8'h00, 1'b0, 2'd0);
        chk("reset.q_valid", 32'(bus.q_valid), 32'd0);
        rst = 1'b0;

        // round robin from reset (last = 3, so requester 0 wins first)
        bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req   = 4'b1111;
        tick(); chk_out("rr1", 4'b0001, 8'h00, 1'b0, 2'd0);
        tick(); chk_out("rr2", 4'b0010, 8'h11, 1'b1, 2'd0);
        chk("rr2.q_valid", 32'(bus.q_valid), 32'd1);
        tick(); chk_out("rr3", 4'b0100, 8'h22, 1'b1, 2'd1);
        tick(); chk_out("rr4", 4'b1000, 8'h33, 1'b1, 2'd2);
        tick(); chk_out("rr5", 4'b0001, 8'h44, 1'b1, 2'd3);
        bus.req = 4'b0000;
        tick(); chk_out("rr_idle", 4'b0000, 8'h44, 1'b0, 2'd3);

        // single write
        bus.wdata = {8'h00, 8'h00, 8'h00, 8'h3C};
        bus.req   = 4'b0001;
        tick(); chk_out("single_gnt", 4'b0001, 8'h44, 1'b0, 2'd3);
        tick(); chk_out("single_wr", 4'b0001, 8'h3C, 1'b1, 2'd0);
        bus.req = 4'b0000;
        tick(); chk_out("single_rel", 4'b0000, 8'h3C, 1'b0, 2'd0);
        chk("single.q_valid", 32'(bus.q_valid), 32'd1);

        // lock cap: exactly four writes from 0, then straight to 2
        bus.wdata = {8'h00, 8'hC2, 8'h00, 8'hA0};
        bus.req   = 4'b0001;
        bus.lock  = 4'b0001;
        tick(); chk_out("cap_gnt", 4'b0001, 8'h3C, 1'b0, 2'd0);
        bus.req = 4'b0101;
        tick(); chk_out("cap_w1", 4'b0001, 8'hA0, 1'b1, 2'd0);
        tick(); chk_out("cap_w2", 4'b0001, 8'hA0, 1'b1, 2'd0);
        tick(); chk_out("cap_w3", 4'b0001, 8'hA0, 1'b1, 2'd0);
        tick(); chk_out("cap_w4", 4'b0100, 8'hA0, 1'b1, 2'd0);

        // early drop: locked owner 2 writes once, then drops with 1 pending
        bus.req  = 4'b0110;
        bus.lock = 4'b0100;
        tick(); chk_out("drop_wr", 4'b0100, 8'hC2, 1'b1, 2'd2);
        bus.req = 4'b0010;
        tick(); chk_out("drop_rel", 4'b0010, 8'hC2, 1'b0, 2'd2);

        // asynchronous reset in the middle of a locked burst
        bus.wdata = {8'h00, 8'h00, 8'hA5, 8'h00};
        bus.lock  = 4'b0010;
        tick(); chk_out("pre_rst", 4'b0010, 8'hA5, 1'b1, 2'd1);
        #2 rst = 1'b1;
        #1 chk_out("async_rst", 4'b0000, 8'h00, 1'b0, 2'd0);
        chk("async_rst.q_valid", 32'(bus.q_valid), 32'd0);
        rst = 1'b0;

        // sole requester is re-granted on every release
        bus.req   = 4'b0100;
        bus.lock  = 4'b0000;
        bus.wdata = {8'h00, 8'h61, 8'h00, 8'h00};
        tick(); chk_out("sole_gnt", 4'b0100, 8'h00, 1'b0, 2'd0);
        tick(); chk_out("sole_w1", 4'b0100, 8'h61, 1'b1, 2'd2);
        bus.wdata = {8'h00, 8'h62, 8'h00, 8'h00};
        tick(); chk_out("sole_w2", 4'b0100, 8'h62, 1'b1, 2'd2);
        bus.wdata = {8'h00, 8'h63, 8'h00, 8'h00};
        tick(); chk_out("sole_w3", 4'b0100, 8'h63, 1'b1, 2'd2);
        bus.req = 4'b0000;
        tick(); chk_out("sole_idle", 4'b0000, 8'h63, 1'b0, 2'd2);
        chk("sole.q_valid", 32'(bus.q_valid), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
